// File: rtl/ips_line_tracker.sv
// rtl/ips_line_tracker.sv - IPS sensor bar line follower: sync, debounce, classify, lost-line FSM, PWM
// Bit NUM_SENSORS-1 is the leftmost sensor; the centre bit votes for neither side.

module ips_line_tracker #(
  parameter int NUM_SENSORS  = 5,
  parameter int FILTER_LEN   = 4,
  parameter int PWM_BITS     = 8,
  parameter int SPEED_FAST   = 200,
  parameter int SPEED_SLOW   = 100,
  parameter int LOST_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] ips,
  output logic                   IN1,
  output logic                   IN2,
  output logic                   IN3,
  output logic                   IN4,
  output logic                   ENA,
  output logic                   ENB,
  output logic [1:0]             state,
  output logic                   lost
);

  localparam int C  = (NUM_SENSORS - 1) / 2;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(LOST_TIMEOUT);
  localparam int CW = $clog2(NUM_SENSORS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_SEARCH = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_NONE     = 2'd0,
    C_LEFT     = 2'd1,
    C_RIGHT    = 2'd2,
    C_STRAIGHT = 2'd3
  } cls_t;

  logic [NUM_SENSORS-1:0] sync1_q;
  logic [NUM_SENSORS-1:0] sync2_q;
  logic [NUM_SENSORS-1:0] filt_q;
  logic [FW-1:0]          fcnt_q [NUM_SENSORS];

  state_t               state_q, state_d;
  cls_t                 last_side_q, last_side_d;
  cls_t                 cls;
  logic [TW-1:0]        timer_q, timer_d;
  logic [PWM_BITS-1:0]  pwm_q;
  logic [PWM_BITS-1:0]  duty_d;
  logic                 drive_d, in1_d, in3_d;
  logic                 in1_q, in2_q, in3_q, in4_q, en_q;
  logic [CW-1:0]        lc, rc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ips;
      sync2_q <= sync1_q;
    end
  end

  // A bit flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lc = '0;
    rc = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (i > C && filt_q[i]) lc = lc + CW'(1);
      if (i < C && filt_q[i]) rc = rc + CW'(1);
    end
    if (filt_q == '0)  cls = C_NONE;
    else if (lc > rc)  cls = C_LEFT;
    else if (rc > lc)  cls = C_RIGHT;
    else               cls = C_STRAIGHT;
  end

  always_comb begin
    state_d     = state_q;
    last_side_d = last_side_q;
    timer_d     = timer_q;
    drive_d     = 1'b0;
    in1_d       = 1'b0;
    in3_d       = 1'b0;
    duty_d      = '0;
    case (state_q)
      S_IDLE: begin
        state_d = S_TRACK;
      end
      S_TRACK: begin
        drive_d = 1'b1;
        if (cls == C_NONE) begin
          // Start steering toward the remembered side on the same edge we give up.
          state_d = S_SEARCH;
          timer_d = '0;
          in1_d   = (last_side_q == C_LEFT);
          in3_d   = (last_side_q == C_RIGHT);
          duty_d  = PWM_BITS'(SPEED_SLOW);
        end else begin
          last_side_d = cls;
          in1_d       = (cls != C_RIGHT);
          in3_d       = (cls != C_LEFT);
          duty_d      = (cls == C_STRAIGHT) ? PWM_BITS'(SPEED_FAST) : PWM_BITS'(SPEED_SLOW);
        end
      end
      S_SEARCH: begin
        drive_d = 1'b1;
        in1_d   = (last_side_q == C_LEFT);
        in3_d   = (last_side_q == C_RIGHT);
        duty_d  = PWM_BITS'(SPEED_SLOW);
        timer_d = timer_q + 1'b1;
        if (cls != C_NONE)                          state_d = S_TRACK;
        else if (timer_q == TW'(LOST_TIMEOUT - 1))  state_d = S_STOP;
      end
      default: ;
    endcase
    if (!enable) begin
      state_d     = S_IDLE;
      last_side_d = last_side_q;
      drive_d     = 1'b0;
      duty_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_side_q <= C_STRAIGHT;
      timer_q     <= '0;
      pwm_q       <= '0;
      in1_q       <= 1'b0;
      in2_q       <= 1'b0;
      in3_q       <= 1'b0;
      in4_q       <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_side_q <= last_side_d;
      timer_q     <= timer_d;
      pwm_q       <= pwm_q + 1'b1;
      in1_q       <= drive_d & in1_d;
      in2_q       <= drive_d & ~in1_d;
      in3_q       <= drive_d & in3_d;
      in4_q       <= drive_d & ~in3_d;
      en_q        <= (pwm_q < duty_d);
    end
  end

  assign IN1   = in1_q;
  assign IN2   = in2_q;
  assign IN3   = in3_q;
  assign IN4   = in4_q;
  assign ENA   = en_q;
  assign ENB   = en_q;
  assign state = state_q;
  assign lost  = (state_q == S_STOP);

endmodule

// File: doc/ips_line_tracker.md
Name: ips_line_tracker

Overview:
- Parametrised successor to the 3-sensor IPS alignment logic.
- Takes an N-wide IPS sensor bar and produces H-bridge direction outputs IN1..IN4 plus PWM enables ENA/ENB.
- Adds input synchronisation and debounce, proportional speed selection, and a lost-line recovery state machine with timeout stop.
- Sits between the IPS sensor pins and the motor driver in the robot top level.

Parameters:
- NUM_SENSORS, 5, sensor count; odd, >=3. Bit NUM_SENSORS-1 is leftmost; centre index C=(NUM_SENSORS-1)/2.
- FILTER_LEN, 4, consecutive stable synchronised samples needed before a sensor bit changes; >=1.
- PWM_BITS, 8, PWM counter width.
- SPEED_FAST, 200, duty used when straight.
- SPEED_SLOW, 100, duty used when turning, searching or reversing.
- LOST_TIMEOUT, 1000, cycles in SEARCH before STOP; >=2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; 0 forces IDLE.
- ips  in  NUM_SENSORS  raw sensor pins; 1 = line detected.
- IN1  out  1  motor A direction.
- IN2  out  1  motor A direction complement.
- IN3  out  1  motor B direction.
- IN4  out  1  motor B direction complement.
- ENA  out  1  motor A PWM enable.
- ENB  out  1  motor B PWM enable.
- state  out  2  FSM state: IDLE=0, TRACK=1, SEARCH=2, STOP=3.
- lost  out  1  high while in STOP.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - IN1..IN4, ENA, ENB and lost = 0; state = IDLE.
  - Synchroniser, filtered bits, filter counters, PWM counter and search timer = 0; last_side = STRAIGHT.
- Input path:
  - 2-flop synchroniser per bit.
  - Per-bit filter: counter increments while the synchronised bit differs from the filtered bit and clears when they match. When the count reaches FILTER_LEN-1 with the bits still differing, the filtered bit takes the new value on that edge and the counter clears.
  - A glitch shorter than FILTER_LEN cycles is never seen.
- Classification (combinational on filtered bits):
  - lc = number of active bits above C; rc = number of active bits below C; any = OR of all bits.
  - !any gives NONE; lc>rc gives LEFT; rc>lc gives RIGHT; lc==rc gives STRAIGHT (includes centre-only and all-on).
- Direction codes for (IN1,IN3): forward (1,1), left (1,0), right (0,1), reverse (0,0).
  - IN2=~IN1 and IN4=~IN3 in TRACK and SEARCH.
  - IN1..IN4 all 0 in IDLE and STOP.
- PWM:
  - Free-running PWM_BITS counter, wraps at 2^PWM_BITS-1 to 0; runs in all states.
  - ENA = ENB = (cnt < duty), registered. duty = 0 gives a constant 0.
  - duty is 0 in IDLE and STOP.
- FSM, registered, one transition per edge:
  - Any state with enable=0 goes to IDLE on the next edge; this has priority over every other transition.
  - IDLE with enable=1 goes to TRACK.
  - TRACK, class != NONE:
    - Drive the class direction; STRAIGHT maps to forward.
    - duty = SPEED_FAST if STRAIGHT, else SPEED_SLOW.
    - last_side <= class.
  - TRACK, class == NONE: go to SEARCH; timer <= 0.
  - SEARCH:
    - Drive toward last_side: LEFT gives left, RIGHT gives right, STRAIGHT gives reverse. duty = SPEED_SLOW; timer increments.
    - class != NONE: go to TRACK; a line seen on the final timeout cycle wins over STOP.
    - Else, when timer == LOST_TIMEOUT-1: go to STOP.
  - STOP: lost=1; remains in STOP even if the line reappears; leaves only via enable=0.
- Outputs are registered from the current state and class.
- Latency, ips pin to IN outputs: a stable change appears FILTER_LEN+3 rising edges after the first edge that samples the new pin value.

Test Plan:
1. Reset mid-run: assert rst_n=0 while in TRACK, forward -> all outputs 0 and state=0 immediately, without waiting for a clock edge; release with enable=1 -> state=1 after 1 edge.
2. Debounce: ips=5'b00100 stable, then a 3-cycle pulse to 5'b10000 -> output stays forward (IN1..IN4=1,0,1,0). Hold the pulse for 4 cycles -> left (1,0,0,1) exactly 7 edges after the first sampling edge.
3. Classification: ips=5'b00011 -> right (0,1,1,0) with duty 100; 5'b11111 -> forward with duty 200; 5'b00100 -> forward.
4. PWM: in TRACK straight with SPEED_FAST=200 over 256 cycles -> ENA high for exactly 200 cycles. SPEED_SLOW=0 while turning -> ENA/ENB stay 0.
5. Lost line: last_side=RIGHT, then ips=0 -> SEARCH driving right. Line restored on timer=500 -> TRACK. With no line, STOP after 1000 SEARCH cycles with lost=1; a line then appearing keeps STOP; enable=0 -> IDLE.
6. Edge race: line reappears on exactly the timer==999 cycle -> TRACK, not STOP. enable=0 in SEARCH -> IDLE next edge with outputs all 0.
